// File: rtl/hk_mash_nth_dithered.sv
// hk_mash_nth_dithered
// HK-MASH 1-1-...-1 delta-sigma modulator with ORDER stages. Stage 1 is an
// HK-EFM accumulator; A_GAIN times its previous carry is fed back, so its
// effective modulus is 2^WIDTH - A_GAIN. Stages 2..ORDER are plain
// error-feedback accumulators chained within the same cycle. The input word
// arrives through a ready/valid handshake into a shadow register. It becomes
// the active word only at the end of a frame of UPD_PERIOD enabled cycles.
//
// Optional build macro: HKMASH_DITHER_EN adds a 23-bit LFSR dither bit at the
// stage-1 LSB. Without the macro, the output is a deterministic sequence.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   en_i       run enable; low freezes all modulator state
//   x_i        unsigned input word
//   x_valid_i  input word offered
//   x_ready_o  shadow register empty
//   y_o        signed modulator output, ORDER+1 bits two's complement
//   y_valid_o  y_o carries a new sample
//   e_o        stage-1 residue
module hk_mash_nth_dithered #(
  parameter int WIDTH      = 24,
  parameter int ORDER      = 3,
  parameter int A_GAIN     = 2,
  parameter int UPD_PERIOD = 1,
  parameter int OUT_REG    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [WIDTH-1:0]        x_i,
  input  logic                    x_valid_i,
  output logic                    x_ready_o,
  output logic signed [ORDER:0]   y_o,
  output logic                    y_valid_o,
  output logic [WIDTH-1:0]        e_o
);

  localparam int FCW = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(UPD_PERIOD - 1);
  localparam logic [WIDTH+1:0] A_EXT = (WIDTH+2)'(A_GAIN);

  logic [WIDTH-1:0] x_act;
  logic [WIDTH-1:0] shadow;
  logic             shadow_full;
  logic [FCW-1:0]   fc;
  logic             c1_prev;
  logic             dith;

  logic [WIDTH-1:0] e_q [ORDER];
  logic [WIDTH-1:0] e_d [ORDER];
  // p_q[k] holds p_(k+1) of the last enabled cycle; p_q[0] is also the
  // registered output sample.
  logic [ORDER:0]   p_q [ORDER];
  logic [ORDER:0]   p_d [ORDER];
  logic [ORDER-1:0] c;

  logic [WIDTH+1:0] s1;
  logic [WIDTH:0]   sk;

`ifdef HKMASH_DITHER_EN
  logic [22:0] lfsr;

  // Fibonacci LFSR, x^23 + x^18 + 1
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 23'd1;
    end else if (en_i) begin
      lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
    end
  end

  assign dith = lfsr[22];
`else
  assign dith = 1'b0;
`endif

  always_comb begin
    s1  = '0;
    sk  = '0;
    c   = '0;
    e_d = e_q;
    p_d = p_q;

    s1 = {2'b00, x_act} + {2'b00, e_q[0]} + (c1_prev ? A_EXT : '0)
       + {{(WIDTH+1){1'b0}}, dith};
    // s1 can exceed 2^(WIDTH+1) only through the feedback term; any bit
    // above WIDTH-1 means a carry.
    c[0]   = |s1[WIDTH+1:WIDTH];
    e_d[0] = s1[WIDTH-1:0];

    for (int k = 1; k < ORDER; k++) begin
      sk     = {1'b0, e_d[k-1]} + {1'b0, e_q[k]};
      c[k]   = sk[WIDTH];
      e_d[k] = sk[WIDTH-1:0];
    end

    // Noise cancellation, last stage back to the first. Arithmetic is modulo
    // 2^(ORDER+1), so two's-complement results fall out naturally.
    p_d[ORDER-1] = {{ORDER{1'b0}}, c[ORDER-1]};
    for (int k = ORDER - 2; k >= 0; k--) begin
      p_d[k] = {{ORDER{1'b0}}, c[k]} + p_d[k+1] - p_q[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_act       <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      fc          <= '0;
      c1_prev     <= 1'b0;
      for (int k = 0; k < ORDER; k++) begin
        e_q[k] <= '0;
        p_q[k] <= '0;
      end
    end else begin
      // Accepting requires an empty shadow, while a frame-end transfer
      // requires a full one, so the two updates never collide.
      if (x_valid_i && !shadow_full) begin
        shadow      <= x_i;
        shadow_full <= 1'b1;
      end
      if (en_i) begin
        e_q     <= e_d;
        p_q     <= p_d;
        c1_prev <= c[0];
        if (fc == FC_LAST) begin
          fc <= '0;
          if (shadow_full) begin
            x_act       <= shadow;
            shadow_full <= 1'b0;
          end
        end else begin
          fc <= fc + 1'b1;
        end
      end
    end
  end

  assign x_ready_o = !shadow_full;
  assign e_o       = e_q[0];

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic y_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          y_valid_q <= 1'b0;
        end else begin
          y_valid_q <= en_i;
        end
      end

      assign y_o       = p_q[0];
      assign y_valid_o = y_valid_q;
    end else begin : g_out_comb
      assign y_o       = p_d[0];
      assign y_valid_o = en_i;
    end
  endgenerate

endmodule

// File: tb/tb_hk_mash_nth_dithered.sv
module tb_hk_mash_nth_dithered;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // a: ORDER 1, WIDTH 4, A 0, registered output
  logic a_en, a_xv, a_rdy, a_yv;
  logic [3:0] a_x, a_e;
  logic [1:0] a_y;
  hk_mash_nth_dithered #(.WIDTH(4), .ORDER(1), .A_GAIN(0), .UPD_PERIOD(1), .OUT_REG(1)) u_a (
    .clk(clk), .rst(rst), .en_i(a_en), .x_i(a_x), .x_valid_i(a_xv),
    .x_ready_o(a_rdy), .y_o(a_y), .y_valid_o(a_yv), .e_o(a_e));

  // b: ORDER 3, WIDTH 4, A 2, registered output, scoreboarded
  logic b_en, b_xv, b_rdy, b_yv;
  logic [3:0] b_x, b_e;
  logic [3:0] b_y;
  hk_mash_nth_dithered #(.WIDTH(4), .ORDER(3), .A_GAIN(2), .UPD_PERIOD(1), .OUT_REG(1)) u_b (
    .clk(clk), .rst(rst), .en_i(b_en), .x_i(b_x), .x_valid_i(b_xv),
    .x_ready_o(b_rdy), .y_o(b_y), .y_valid_o(b_yv), .e_o(b_e));

  // c: ORDER 2, WIDTH 8, A 0, frame of 16, combinational output
  logic c_en, c_xv, c_rdy, c_yv;
  logic [7:0] c_x, c_e;
  logic [2:0] c_y;
  hk_mash_nth_dithered #(.WIDTH(8), .ORDER(2), .A_GAIN(0), .UPD_PERIOD(16), .OUT_REG(0)) u_c (
    .clk(clk), .rst(rst), .en_i(c_en), .x_i(c_x), .x_valid_i(c_xv),
    .x_ready_o(c_rdy), .y_o(c_y), .y_valid_o(c_yv), .e_o(c_e));

  // d: ORDER 3, WIDTH 4, A 0, x = 0, combinational output (dither test)
  logic d_en, d_xv, d_rdy, d_yv;
  logic [3:0] d_x, d_e;
  logic [3:0] d_y;
  hk_mash_nth_dithered #(.WIDTH(4), .ORDER(3), .A_GAIN(0), .UPD_PERIOD(1), .OUT_REG(0)) u_d (
    .clk(clk), .rst(rst), .en_i(d_en), .x_i(d_x), .x_valid_i(d_xv),
    .x_ready_o(d_rdy), .y_o(d_y), .y_valid_o(d_yv), .e_o(d_e));

  // Reference model for instance b; pushes one expected sample per enabled edge.
  typedef struct { int y; int e; } sb_t;
  sb_t sbq[$];
  sb_t ent;
  int m_x, m_sh, m_e0, m_e1, m_e2, m_pp2, m_pp3, m_s;
  int m_c1, m_c2, m_c3, m_p1, m_p2, m_p3;
  bit m_full, m_c1p, m_acc;

  always @(posedge clk) begin
    if (rst) begin
      m_x = 0; m_sh = 0; m_full = 0; m_c1p = 0;
      m_e0 = 0; m_e1 = 0; m_e2 = 0; m_pp2 = 0; m_pp3 = 0;
      sbq.delete();
    end else begin
      m_acc = b_xv && !m_full;
      if (b_en) begin
        m_s  = m_x + m_e0 + (m_c1p ? 2 : 0);
        m_c1 = (m_s >= 16) ? 1 : 0;  m_e0 = m_s % 16;
        m_s  = m_e0 + m_e1;
        m_c2 = (m_s >= 16) ? 1 : 0;  m_e1 = m_s % 16;
        m_s  = m_e1 + m_e2;
        m_c3 = (m_s >= 16) ? 1 : 0;  m_e2 = m_s % 16;
        m_p3 = m_c3;
        m_p2 = m_c2 + m_p3 - m_pp3;
        m_p1 = m_c1 + m_p2 - m_pp2;
        m_pp3 = m_p3; m_pp2 = m_p2; m_c1p = m_c1[0];
        ent.y = m_p1; ent.e = m_e0;
        sbq.push_back(ent);
        if (m_full) begin m_x = m_sh; m_full = 0; end
      end
      if (m_acc) begin m_sh = int'(b_x); m_full = 1; end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_yv) begin
      chk("sb_nonempty", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        ent = sbq.pop_front();
        chk("sb_y", $signed(b_y), ent.y);
        chk("sb_e", b_e, ent.e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int sum, bad, nz, delta, prev_e, exp_d, exp_r, yv;
  logic [3:0] fe;
  logic [3:0] fy;
  int a_ey[4] = '{0, 0, 0, 1};
  int a_ee[4] = '{4, 8, 12, 0};

  initial begin
    rst = 1'b1;
    a_en = 0; a_xv = 0; a_x = 0;
    b_en = 0; b_xv = 0; b_x = 0;
    c_en = 0; c_xv = 0; c_x = 0;
    d_en = 0; d_xv = 0; d_x = 0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_y", $signed(b_y), 0);
    chk("rst_yv", b_yv, 0);
    chk("rst_e", b_e, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", b_rdy, 1);

    // Accept 8 while disabled, then run 2744 samples
    b_x = 4'd8; b_xv = 1'b1;
    @(negedge clk);
    b_xv = 1'b0;
    chk("acc8_rdy_low", b_rdy, 0);
    b_en = 1'b1;
    @(negedge clk);
    chk("wrap_rdy_high", b_rdy, 1);
    sum = 0; bad = 0;
    for (int i = 0; i < 2744; i++) begin
      @(negedge clk);
      yv = int'($signed(b_y));
      sum += yv;
      if (yv < -3 || yv > 4) bad++;
    end
    chk("b_range_violations", bad, 0);
    chk("b_sum_within_4", (sum >= 1564 && sum <= 1572), 1);
    if (!(sum >= 1564 && sum <= 1572)) $display("sum of y = %0d", sum);

    // Freeze for 50 cycles, then resume under the scoreboard
    b_en = 1'b0;
    fe = b_e; fy = b_y;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("frz_yv", b_yv, 0);
      chk("frz_e", b_e, fe);
      chk("frz_y", b_y, fy);
    end
    b_en = 1'b1;
    repeat (100) @(negedge clk);
    b_en = 1'b0;
    @(negedge clk);

    // ORDER 1, x = 4: y 0,0,0,1 and e 4,8,12,0
    a_x = 4'd4; a_xv = 1'b1;
    @(negedge clk);
    a_xv = 1'b0; a_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("o1_y", $signed(a_y), a_ey[i % 4]);
      chk("o1_e", a_e, a_ee[i % 4]);
      chk("o1_yv", a_yv, 1);
    end
    a_en = 1'b0;

    // UPD_PERIOD 16: back-to-back offers, x_act inferred from e_o steps
    c_en = 1'b1; c_xv = 1'b1; c_x = 8'd5;
    prev_e = int'(c_e);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      delta = (int'(c_e) - prev_e) & 255;
      prev_e = int'(c_e);
      exp_d = (k <= 16) ? 0 : ((k <= 32) ? 5 : 9);
      exp_r = (k <= 15) ? 0 : ((k == 16) ? 1 : ((k <= 31) ? 0 : 1));
      chk($sformatf("fr_xact_step_%0d", k), delta, exp_d);
      chk($sformatf("fr_ready_%0d", k), c_rdy, exp_r);
      chk("fr_comb_yv", c_yv, 1);
      if (k == 1) c_x = 8'd9;
      if (k == 17) c_xv = 1'b0;
    end
    c_en = 1'b0;
    #1;
    chk("fr_comb_yv_off", c_yv, 0);

    // Dither instance, x = 0, A = 0
    d_en = 1'b1;
    bad = 0; nz = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      yv = int'($signed(d_y));
      if (yv < -3 || yv > 4) bad++;
      if (yv != 0) nz++;
    end
    d_en = 1'b0;
    chk("d_range_violations", bad, 0);
`ifdef HKMASH_DITHER_EN
    chk("d_nonzero_seen", nz > 0, 1);
`else
    chk("nodither_nonzero_count", nz, 0);
`endif

    // Reset mid-operation discards a pending shadow word
    @(negedge clk);
    c_x = 8'd77; c_xv = 1'b1;
    @(negedge clk);
    c_xv = 1'b0;
    chk("pend_rdy_low", c_rdy, 0);
    b_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b_en = 1'b0;
    chk("mid_rst_rdy", c_rdy, 1);
    chk("mid_rst_e", c_e, 0);
    chk("mid_rst_b_e", b_e, 0);
    chk("mid_rst_b_y", $signed(b_y), 0);
    chk("mid_rst_b_yv", b_yv, 0);
    c_en = 1'b1;
    repeat (20) @(negedge clk);
    c_en = 1'b0;
    chk("discarded_word_e", c_e, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
